// File: rtl/vram_arbiter.sv
// Arbitrates the single-port graphics RAM between the display pixel fetch (always wins)
// and the CPU, whose writes are posted into a small FIFO and whose reads wait behind them.
module vram_arbiter #(
    parameter int DEPTH     = 4,
    parameter int VRAM_SIZE = 64000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_req,
    input  logic [15:0] disp_addr,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [16:0]   LIMIT    = 17'(VRAM_SIZE);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [15:0]   r_fifo_addr [DEPTH];
    logic [7:0]    r_fifo_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic        r_disp_p1;
    logic        r_disp_oor_p1;
    logic [7:0]  r_disp_data;
    logic        r_disp_valid;
    logic        r_rd_oor;
    logic [7:0]  r_cpu_rdata;

    logic        w_empty;
    logic        w_full;
    logic        w_gnt_disp;
    logic        w_gnt_fifo;
    logic        w_gnt_rd;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head_addr;
    logic [7:0]  w_head_data;
    logic        w_disp_inr;
    logic        w_head_inr;
    logic        w_cpu_inr;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_disp_inr  = ({1'b0, disp_addr}   < LIMIT);
    assign w_head_inr  = ({1'b0, w_head_addr} < LIMIT);
    assign w_cpu_inr   = ({1'b0, cpu_addr}    < LIMIT);

    // Grants are gated by rst_n so the RAM port is quiet while reset is held.
    assign w_gnt_disp = rst_n & disp_req;
    assign w_gnt_fifo = rst_n & ~disp_req & ~w_empty;
    assign w_gnt_rd   = rst_n & ~disp_req & w_empty & (r_state == S_IDLE) & cpu_req & ~cpu_we;
    assign w_pop      = w_gnt_fifo;
    assign w_push     = (r_state == S_IDLE) & cpu_req & cpu_we & ~w_full;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_gnt_disp) begin
            mem_addr = w_disp_inr ? disp_addr : '0;
        end else if (w_gnt_fifo) begin
            mem_addr  = w_head_inr ? w_head_addr : '0;
            mem_we    = w_head_inr;
            mem_wdata = w_head_inr ? w_head_data : '0;
        end else if (w_gnt_rd) begin
            mem_addr = w_cpu_inr ? cpu_addr : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_addr;
            r_fifo_data[r_wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Display pipeline: grant in T, RAM data in T+1, registered output visible in T+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_p1     <= 1'b0;
            r_disp_oor_p1 <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_disp_data   <= '0;
        end else begin
            r_disp_p1     <= w_gnt_disp;
            r_disp_oor_p1 <= ~w_disp_inr;
            r_disp_valid  <= r_disp_p1;
            if (r_disp_p1) r_disp_data <= r_disp_oor_p1 ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_oor    <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            if (w_gnt_rd) r_rd_oor <= ~w_cpu_inr;
            if (r_state == S_RD_WAIT) r_cpu_rdata <= r_rd_oor ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_push)        w_next_state = S_ACK;
                else if (w_gnt_rd) w_next_state = S_RD_WAIT;
            end
            S_RD_WAIT: w_next_state = S_ACK;
            S_ACK:     w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ack = (r_state == S_ACK);
    end

    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign cpu_rdata  = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: display pipeline table plus posted-write, ordering,
// collision, reset and out-of-range sequences against a behavioural synchronous RAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_we    = 0;
    int n_bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;
    wr_t wlog[$];

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic [15:0] exp_maddr;
        logic        exp_v;
        logic [7:0]  exp_d;
    } vec_t;
    vec_t vecs[9];

    logic [7:0] ram [65536];

    vram_arbiter #(.DEPTH(4), .VRAM_SIZE(64000)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back('{mem_addr, mem_wdata, cyc});
        end
        mem_rdata <= ram[mem_addr];
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) n_we++;
        if (disp_req === 1'b1 && mem_we === 1'b1) n_bad++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input int budget, output logic acked, output logic [7:0] rd);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        acked = 1'b0; rd = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                acked = 1'b1;
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         base, we0, n_ack, a_c, r_c, w_c;

        for (int a = 0; a < 65536; a++) ram[a] = a[7:0];
        ram[0] = 8'h5A;

        vecs[0] = '{1'b1, 16'd100,   16'd100, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 16'd101,   16'd101, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 16'd102,   16'd102, 1'b1, 8'd100};
        vecs[3] = '{1'b1, 16'd103,   16'd103, 1'b1, 8'd101};
        vecs[4] = '{1'b0, 16'd0,     16'd0,   1'b1, 8'd102};
        vecs[5] = '{1'b1, 16'd64000, 16'd0,   1'b1, 8'd103};
        vecs[6] = '{1'b0, 16'd0,     16'd0,   1'b0, 8'h00};
        vecs[7] = '{1'b0, 16'd0,     16'd0,   1'b1, 8'h00};
        vecs[8] = '{1'b0, 16'd0,     16'd0,   1'b0, 8'h00};

        rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #12;
        check("rst_disp_data", disp_data, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        step();
        rst_n = 1'b1;
        step();

        // Display pipeline table
        for (int i = 0; i < 9; i++) begin
            disp_req = vecs[i].req;
            disp_addr = vecs[i].addr;
            @(negedge clk);
            check($sformatf("disp_maddr[%0d]", i), mem_addr, vecs[i].exp_maddr);
            check($sformatf("disp_we[%0d]", i), mem_we, 0);
            check($sformatf("disp_valid[%0d]", i), disp_valid, vecs[i].exp_v);
            if (vecs[i].exp_v) check($sformatf("disp_data[%0d]", i), disp_data, vecs[i].exp_d);
            step();
        end

        // Posted writes with display saturating the RAM
        disp_req = 1'b1; disp_addr = 16'd200;
        for (int k = 0; k < 4; k++) begin
            cpu_txn(1'b1, 16'(1000 + k), 8'(8'h10 + k), 8, ack, rd);
            check($sformatf("post_ack[%0d]", k), ack, 1);
        end
        cpu_we = 1'b1; cpu_addr = 16'd1004; cpu_wdata = 8'h14; cpu_req = 1'b1;
        n_ack = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (cpu_ack) n_ack++;
            step();
        end
        check("full_stall_no_ack", n_ack, 0);
        check("no_we_under_disp", n_bad, 0);
        base = wlog.size();
        disp_req = 1'b0;
        ack = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ack = 1'b1;
                cpu_req = 1'b0;
                break;
            end
            step();
        end
        check("fifth_ack", ack, 1);
        cpu_req = 1'b0;
        for (int j = 0; j < 5; j++) step();
        check("drain_count", wlog.size() - base, 5);
        if (wlog.size() - base == 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("drain_addr[%0d]", k), wlog[base + k].a, 1000 + k);
                check($sformatf("drain_data[%0d]", k), wlog[base + k].d, 8'h10 + k);
                if (k > 0) check($sformatf("drain_cyc[%0d]", k), wlog[base + k].c - wlog[base + k - 1].c, 1);
            end
        end

        // Read-after-write ordering
        disp_req = 1'b1; disp_addr = 16'd210;
        cpu_txn(1'b1, 16'd500, 8'hA5, 8, ack, rd);
        check("raw_wr_ack", ack, 1);
        cpu_we = 1'b0; cpu_addr = 16'd500; cpu_req = 1'b1;
        n_ack = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (cpu_ack) n_ack++;
            step();
        end
        check("raw_rd_held", n_ack, 0);
        disp_req = 1'b0;
        a_c = -1; r_c = -1; w_c = -1; rd = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 16'd500 && w_c < 0) w_c = j;
            if (!mem_we && mem_addr == 16'd500 && r_c < 0) r_c = j;
            if (cpu_ack && a_c < 0) begin
                a_c = j;
                rd = cpu_rdata;
                cpu_req = 1'b0;
            end
            step();
        end
        check("raw_write_cycle", w_c, 0);
        check("raw_issue_cycle", r_c, 1);
        check("raw_ack_cycle", a_c, 3);
        check("raw_rdata", rd, 8'hA5);

        // Collision: display and CPU read arrive together
        disp_req = 1'b1; disp_addr = 16'd300;
        cpu_we = 1'b0; cpu_addr = 16'd7; cpu_req = 1'b1;
        @(negedge clk);
        check("col_c0_maddr", mem_addr, 300);
        step();
        disp_req = 1'b0;
        @(negedge clk);
        check("col_c1_maddr", mem_addr, 7);
        check("col_c1_ack", cpu_ack, 0);
        step();
        disp_req = 1'b1; disp_addr = 16'd301;
        @(negedge clk);
        check("col_c2_valid", disp_valid, 1);
        check("col_c2_data", disp_data, 8'h2C);
        check("col_c2_maddr", mem_addr, 301);
        step();
        disp_req = 1'b0;
        @(negedge clk);
        check("col_c3_ack", cpu_ack, 1);
        check("col_c3_rdata", cpu_rdata, 8'h07);
        check("col_c3_valid", disp_valid, 0);
        cpu_req = 1'b0;
        step();
        @(negedge clk);
        check("col_c4_valid", disp_valid, 1);
        check("col_c4_data", disp_data, 8'h2D);
        check("col_c4_ack", cpu_ack, 0);
        step();

        // Reset mid-burst with three writes posted
        disp_req = 1'b1; disp_addr = 16'd305;
        for (int k = 0; k < 3; k++) begin
            cpu_txn(1'b1, 16'(2000 + k), 8'(8'h60 + k), 8, ack, rd);
            check($sformatf("rst_post_ack[%0d]", k), ack, 1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_disp_data", disp_data, 0);
        check("arst_disp_valid", disp_valid, 0);
        check("arst_cpu_rdata", cpu_rdata, 0);
        check("arst_cpu_ack", cpu_ack, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        disp_req = 1'b0; cpu_req = 1'b0;
        step();
        rst_n = 1'b1;
        we0 = n_we;
        for (int j = 0; j < 5; j++) step();
        check("post_rst_no_we", n_we - we0, 0);
        cpu_we = 1'b0; cpu_addr = 16'd42; cpu_req = 1'b1;
        @(negedge clk);
        check("post_rst_issue_maddr", mem_addr, 42);
        check("post_rst_issue_we", mem_we, 0);
        step();
        @(negedge clk);
        check("post_rst_rdwait_ack", cpu_ack, 0);
        step();
        @(negedge clk);
        check("post_rst_ack", cpu_ack, 1);
        check("post_rst_rdata", cpu_rdata, 8'h2A);
        cpu_req = 1'b0;
        step();

        // Out-of-range write and read
        we0 = n_we;
        cpu_txn(1'b1, 16'd64010, 8'h55, 8, ack, rd);
        check("oor_wr_ack", ack, 1);
        for (int j = 0; j < 4; j++) step();
        check("oor_no_we", n_we - we0, 0);
        cpu_txn(1'b0, 16'd64010, 8'h00, 8, ack, rd);
        check("oor_rd_ack", ack, 1);
        check("oor_rdata", rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
